sa_autosa_shiftleft_sat_pipe: RTL and testbench

SA_AUTOSA_SHIFTLEFT_SAT_PIPE -- requirements
Module: sa_autosa_shiftleft_sat_pipe

---
 rtl/sa_autosa_shift_pkg.sv | 23 ++
 rtl/sa_autosa_shiftleft_core.sv | 69 ++++++
 rtl/sa_autosa_shiftleft_sat_pipe.sv | 99 +++++++++
 tb/tb_sa_autosa_shiftleft_sat_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_autosa_shift_pkg.sv
// Shared widths and saturation constants for the shift/saturate pipe.
package sa_autosa_shift_pkg;

  localparam int IN_WIDTH_DEF    = 32;
  localparam int OUT_WIDTH_DEF   = 49;
  localparam int SHIFT_WIDTH_DEF = 6;
  localparam int SHIFT_MAX_DEF   = 1 << (SHIFT_WIDTH_DEF - 1);
  localparam int STAGES          = 2;

  // Wide enough for any output width this block would realistically use.
  localparam int SAT_CW = 128;

  // Largest positive value representable on w signed bits.
  function automatic logic [SAT_CW-1:0] sat_max(input int w);
    return (SAT_CW'(1) << (w - 1)) - SAT_CW'(1);
  endfunction

  // Most negative value on w signed bits (low w bits are 100..0).
  function automatic logic [SAT_CW-1:0] sat_min(input int w);
    return {SAT_CW{1'b1}} << (w - 1);
  endfunction

endpackage

// File: rtl/sa_autosa_shiftleft_core.sv
// Combinational math for the shift pipe: the shift half feeds S1, the
// round/clamp half turns S1 contents into the S2 result.
module sa_autosa_shiftleft_core
  import sa_autosa_shift_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic [OUT_WIDTH-1:0]   sh_val,
  output logic                   sh_rnd,
  output logic                   sh_sat,
  output logic                   sh_neg,
  input  logic [OUT_WIDTH-1:0]   s1_val,
  input  logic                   s1_rnd,
  input  logic                   s1_sat,
  input  logic                   s1_neg,
  output logic [OUT_WIDTH-1:0]   res_data,
  output logic                   res_sat
);

  localparam int SHIFT_MAX = 1 << (SHIFT_WIDTH - 1);
  localparam int WIDE      = IN_WIDTH + SHIFT_MAX;
  localparam logic [OUT_WIDTH-1:0] MAXV = OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] MINV = OUT_WIDTH'(sat_min(OUT_WIDTH));

  logic signed [WIDE-1:0]      ext;
  logic signed [WIDE-1:0]      shifted;
  logic [WIDE-OUT_WIDTH:0]     top;
  logic [SHIFT_WIDTH-1:0]      mag;
  logic                        right, big, guide, sticky;

  // Shift on the full wide word; guide/sticky only matter for right shifts.
  always_comb begin
    right   = in_shift[SHIFT_WIDTH-1];
    mag     = right ? -in_shift : in_shift;
    ext     = {{SHIFT_MAX{in_data[IN_WIDTH-1]}}, in_data};
    big     = right && (int'(mag) >= IN_WIDTH);
    guide   = 1'b0;
    sticky  = 1'b0;
    shifted = ext << mag;
    if (right) begin
      if (big) begin
        shifted = '0;
      end else begin
        shifted = ext >>> mag;
        guide   = |(ext & (WIDE'(1) << (mag - SHIFT_WIDTH'(1))));
        sticky  = |(ext & ((WIDE'(1) << (mag - SHIFT_WIDTH'(1))) - WIDE'(1)));
      end
    end
    top    = shifted[WIDE-1:OUT_WIDTH-1];
    // Overflow when the bits above the output sign bit are not a sign copy.
    sh_sat = ~right & ~((&top) | ~(|top));
    sh_neg = shifted[WIDE-1];
    sh_val = shifted[OUT_WIDTH-1:0];
    // Half away from zero: negative ties stay at the floor value.
    sh_rnd = guide & (~in_data[IN_WIDTH-1] | sticky);
  end

  // Apply rounding increment or clamp to the representable range.
  always_comb begin
    res_sat  = s1_sat;
    res_data = s1_val + OUT_WIDTH'(s1_rnd);
    if (s1_sat) res_data = s1_neg ? MINV : MAXV;
  end

endmodule

// File: rtl/sa_autosa_shiftleft_sat_pipe.sv
// Two-stage shift/round/saturate pipe with valid/ready handshake and a
// sticky count of clamped output beats.
module sa_autosa_shiftleft_sat_pipe
  import sa_autosa_shift_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic                   autosa_core_clk,
  input  logic                   autosa_core_rst,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  input  logic                   sat_cnt_clr,
  output logic [31:0]            sat_cnt
);

  logic [STAGES:1]        vld_pipe;
  logic [OUT_WIDTH-1:0]   sh_val, s1_val, res_data;
  logic                   sh_rnd, sh_sat, sh_neg, res_sat;
  logic                   s1_rnd, s1_sat, s1_neg;
  logic                   s2_rdy, s1_adv, sat_inc;

  sa_autosa_shiftleft_core #(
    .IN_WIDTH    (IN_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_core (
    .in_data  (in_data),
    .in_shift (in_shift),
    .sh_val   (sh_val),
    .sh_rnd   (sh_rnd),
    .sh_sat   (sh_sat),
    .sh_neg   (sh_neg),
    .s1_val   (s1_val),
    .s1_rnd   (s1_rnd),
    .s1_sat   (s1_sat),
    .s1_neg   (s1_neg),
    .res_data (res_data),
    .res_sat  (res_sat)
  );

  // A stage may load when it is empty or draining this cycle.
  always_comb begin
    s2_rdy   = ~vld_pipe[2] | out_prdy;
    s1_adv   = vld_pipe[1] & s2_rdy;
    in_prdy  = ~autosa_core_rst & (~vld_pipe[1] | s1_adv);
    out_pvld = vld_pipe[2];
    sat_inc  = vld_pipe[2] & out_prdy & out_sat;
  end

  // Pipeline registers; contents hold while the downstream stage is stalled.
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      vld_pipe <= '0;
      s1_val   <= '0;
      s1_rnd   <= 1'b0;
      s1_sat   <= 1'b0;
      s1_neg   <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (in_prdy) begin
        vld_pipe[1] <= in_pvld;
        if (in_pvld) begin
          s1_val <= sh_val;
          s1_rnd <= sh_rnd;
          s1_sat <= sh_sat;
          s1_neg <= sh_neg;
        end
      end
      if (s2_rdy) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data <= res_data;
          out_sat  <= res_sat;
        end
      end
    end
  end

  // Saturated-beat counter: sticks at all-ones, clear loses to a new hit.
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt <= sat_inc ? 32'd1 : 32'd0;
    end else if (sat_inc && (sat_cnt != 32'hFFFF_FFFF)) begin
      sat_cnt <= sat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sa_autosa_shiftleft_sat_pipe.sv
// Scoreboard bench: the driver pushes model results on accept, a monitor
// pops and compares on every output handshake.
module tb_sa_autosa_shiftleft_sat_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_pvld = 1'b0;
  logic        in_prdy;
  logic [31:0] in_data = '0;
  logic [5:0]  in_shift = '0;
  logic        out_pvld;
  wire         out_prdy;
  logic [48:0] out_data;
  logic        out_sat;
  logic        sat_cnt_clr = 1'b0;
  logic [31:0] sat_cnt;

  logic        rand_bp = 1'b0;
  logic        rnd_prdy = 1'b1;
  logic        prdy_set = 1'b1;
  logic        mon_en = 1'b0;
  assign out_prdy = rand_bp ? rnd_prdy : prdy_set;

  int n_chk = 0;
  int n_pass = 0;
  int acc_cnt = 0;
  logic [49:0] exp_q[$];

  sa_autosa_shiftleft_sat_pipe dut (
    .autosa_core_clk (clk),
    .autosa_core_rst (rst),
    .in_pvld         (in_pvld),
    .in_prdy         (in_prdy),
    .in_data         (in_data),
    .in_shift        (in_shift),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_data        (out_data),
    .out_sat         (out_sat),
    .sat_cnt_clr     (sat_cnt_clr),
    .sat_cnt         (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: exact arithmetic on 64-bit integers, then range clamp.
  function automatic logic [48:0] ref_res(input logic [31:0] d, input logic [5:0] sh,
                                          output logic sat);
    int     s;
    int     n;
    longint v, p, m, r;
    longint lim;
    s   = int'($signed(sh));
    v   = longint'($signed(d));
    lim = longint'(1) <<< 48;
    sat = 1'b0;
    if (s >= 0) begin
      p = v * (longint'(1) <<< s);
      if (p > lim - 1) begin sat = 1'b1; return 49'h0_FFFF_FFFF_FFFF; end
      if (p < -lim)    begin sat = 1'b1; return 49'h1_0000_0000_0000; end
      return 49'(p);
    end
    n = -s;
    if (n >= 32) return '0;
    m = (v < 0) ? -v : v;
    r = (m + (longint'(1) <<< (n - 1))) >>> n;
    return 49'((v < 0) ? -r : r);
  endfunction

  task automatic send(input logic [31:0] d, input logic [5:0] s);
    int t;
    logic sat;
    logic [48:0] e;
    in_pvld = 1'b1; in_data = d; in_shift = s; t = 0;
    forever begin
      @(negedge clk);
      if (in_prdy) begin
        e = ref_res(d, s, sat);
        exp_q.push_back({sat, e});
        acc_cnt++;
        @(posedge clk); #1;
        break;
      end
      t++;
      if (t > 200) begin
        chk("accept_timeout", 64'(t), 64'd0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    in_pvld = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t = 0;
    in_pvld = 1'b0;
    while (exp_q.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_pvld && t < 50) begin @(posedge clk); #1; t++; end
    chk("wait_out_pvld", 64'(out_pvld), 64'd1);
  endtask

  // Random downstream stall pattern.
  always @(posedge clk) begin
    #1;
    rnd_prdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor: output beats, hold stability and the saturation counter model.
  logic [31:0] m_cnt = '0;
  logic        hold = 1'b0;
  logic [48:0] hold_data;
  logic        hold_sat;
  always @(negedge clk) begin
    logic [49:0] e;
    logic        inc;
    if (mon_en) begin
      chk("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
      if (rst) begin
        exp_q.delete();
        m_cnt = '0;
        hold  = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_data", 64'(out_data), 64'(hold_data));
          chk("hold_sat", 64'(out_sat), 64'(hold_sat));
        end
        inc = 1'b0;
        if (out_pvld && out_prdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(out_data), 64'd0);
            if (out_data == '0) $display("FAIL unexpected_beat: got a beat expected none");
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e[48:0]));
            chk("out_sat", 64'(out_sat), 64'(e[49]));
            inc = e[49];
          end
        end
        if (sat_cnt_clr) m_cnt = inc ? 32'd1 : 32'd0;
        else if (inc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        hold      = out_pvld && !out_prdy;
        hold_data = out_data;
        hold_sat  = out_sat;
      end
    end
  end

  initial begin
    int a0;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_prdy", 64'(in_prdy), 64'd0);
    chk("rst_out_pvld", 64'(out_pvld), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Latency of a lone beat: S1 after the accept edge, output one edge later.
    send(32'h0000_0003, 6'd4);
    in_pvld = 1'b0;
    @(negedge clk);
    chk("lat_s1_only", 64'(out_pvld), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_out_vld", 64'(out_pvld), 64'd1);
    chk("lat_out_data", 64'(out_data), 64'h30);
    @(posedge clk); #1;

    // Directed saturation and rounding corners.
    send(32'h7FFF_FFFF, 6'd31);
    send(32'h8000_0000, 6'd31);
    send(32'd5, 6'h3F);
    send(32'hFFFF_FFFB, 6'h3F);
    send(32'hFFFF_FFFA, 6'h3E);
    send(32'h1234_5678, 6'h20);
    send(32'h1234_5678, 6'h21);
    send(32'hFFFF_FFFF, 6'h3F);
    send(32'h8000_0000, 6'h21);
    send(32'h0001_0000, 6'd31);
    send(32'h0000_FFFF, 6'd17);
    send(32'hFFFF_0000, 6'd17);
    drain();

    // Backpressure: only two beats fit while the output is stalled.
    prdy_set = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        send(32'd11, 6'd1);
        send(32'd12, 6'd2);
        send(32'd13, 6'd3);
        send(32'd14, 6'd4);
        in_pvld = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", 64'(acc_cnt - a0), 64'd2);
        chk("bp_in_prdy", 64'(in_prdy), 64'd0);
        @(posedge clk); #1;
        prdy_set = 1'b1;
      end
    join
    drain();

    // Clear coincident with a saturated handshake, then clear alone.
    prdy_set = 1'b0;
    send(32'h7FFF_FFFF, 6'd20);
    in_pvld = 1'b0;
    wait_out();
    sat_cnt_clr = 1'b1; prdy_set = 1'b1;
    @(posedge clk); #1;
    sat_cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_with_inc", 64'(sat_cnt), 64'd1);
    @(posedge clk); #1;
    sat_cnt_clr = 1'b1;
    @(posedge clk); #1;
    sat_cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_alone", 64'(sat_cnt), 64'd0);
    @(posedge clk); #1;

    // Reset with beats in flight and a non-zero counter.
    send(32'h4000_0000, 6'd30);
    send(32'hC000_0000, 6'd30);
    send(32'h7FFF_0000, 6'd25);
    drain();
    idle(1);
    chk("pre_rst_cnt", 64'(sat_cnt), 64'd3);
    prdy_set = 1'b0;
    send(32'd100, 6'd1);
    send(32'd200, 6'd1);
    in_pvld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_pvld", 64'(out_pvld), 64'd0);
    chk("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    @(posedge clk); #1;
    prdy_set = 1'b1;
    idle(10);

    // Randomized traffic with random stalls and occasional clears.
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'($urandom_range(0, 255));
        2: d = -32'($urandom_range(0, 255));
        default: case ($urandom_range(0, 3))
          0: d = 32'h7FFF_FFFF;
          1: d = 32'h8000_0000;
          2: d = 32'hFFFF_FFFF;
          default: d = 32'h0;
        endcase
      endcase
      sat_cnt_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(d, 6'($urandom_range(0, 63)));
    end
    sat_cnt_clr = 1'b0;
    in_pvld = 1'b0;
    rand_bp = 1'b0;
    prdy_set = 1'b1;
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
